// File: rtl/jtag_debug_scan_master.sv
// jtag_debug_scan_master: initiator for the virtual-JTAG debug data register.
// Accepts one {IR, DR word} command, generates tck plus the uir/cdr/sdr/udr/rti
// strobes, shifts the word out LSB-first on tdi and returns the captured tdo word.
// Optional IR cache, enabled by defining JTAG_DEBUG_SCAN_IR_CACHE_EN, skips the
// UIR phase when the new IR equals the one already presented to the slave.
module jtag_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int DIVW = $clog2(2 * TCK_DIV);
  localparam int CNTW = $clog2(DR_WIDTH + 1);
  localparam logic [DIVW-1:0] DIV_RISE = DIVW'(TCK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * TCK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
  } state_e;

  state_e                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic                  tck_q, tck_d;
  logic [CNTW-1:0]       bit_q, bit_d;
  logic [DR_WIDTH-1:0]   sh_q, sh_d;
  logic [DR_WIDTH-1:0]   cap_q, cap_d;
  logic [1:0]            ir_q, ir_d;
  logic                  skip_uir;
  logic                  active, tck_rise, period_end;

`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
  // ir_q already holds the last IR shown to the slave; only a valid flag is needed
  logic cache_vld_q;
  assign skip_uir = cache_vld_q && (cmd_ir == ir_q);

  // cache becomes valid on the first accepted command, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              cache_vld_q <= 1'b0;
    else if (state_q == S_IDLE && cmd_valid)   cache_vld_q <= 1'b1;
  end
`else
  assign skip_uir = 1'b0;
`endif

  assign active     = (state_q != S_IDLE) && (state_q != S_RSP);
  assign tck_rise   = (div_q == DIV_RISE);
  assign period_end = (div_q == DIV_LAST);

  // next-state: every tck period is 2*TCK_DIV clk long and starts with tck low;
  // state changes, tdi shifts and strobe changes all land on the tck falling edge
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = 1'b0;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cap_d   = cap_q;
    ir_d    = ir_q;
    if (active) begin
      div_d = period_end ? '0 : div_q + 1'b1;
      tck_d = tck_rise ? 1'b1 : (period_end ? 1'b0 : tck_q);
    end
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        sh_d    = cmd_data;
        ir_d    = cmd_ir;
        bit_d   = CNTW'(DR_WIDTH - 1);
        div_d   = '0;
        state_d = skip_uir ? S_CDR : S_UIR;
      end
      S_UIR: if (period_end) state_d = S_CDR;
      S_CDR: if (period_end) state_d = S_SDR;
      S_SDR: begin
        if (tck_rise) cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
        if (period_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == '0) state_d = S_UDR;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      S_UDR: if (period_end) state_d = S_RTI;
      S_RTI: if (period_end) state_d = S_RSP;
      S_RSP: if (rsp_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any scan in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      tck_q   <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      cap_q   <= '0;
      ir_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      ir_q    <= ir_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_data  = cap_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = sh_q[0];
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state_q == S_UIR);
  assign vji_cdr   = (state_q == S_CDR);
  assign vji_sdr   = (state_q == S_SDR);
  assign vji_udr   = (state_q == S_UDR);
  assign vji_rti   = (state_q == S_RTI);

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Bench for jtag_debug_scan_master: table of scans against a tdo loopback slave
// (tdi delayed one tck, optionally inverted), plus hand-written sequences for
// response back-pressure, back-to-back scans and reset in the middle of SDR.
module tb_jtag_debug_scan_master;
  localparam int DR = 38;
  localparam int TD = 2;
`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [1:0] cmd_ir = 2'b00, vji_ir_in;
  logic [DR-1:0] cmd_data = '0, rsp_data;
  logic vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  jtag_debug_scan_master #(.DR_WIDTH(DR), .TCK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti));

  always #5 clk = ~clk;

  // slave model: tdo is tdi from the previous sdr tck period, cleared at cdr
  logic tdo_dly = 1'b0, tdo_inv = 1'b0;
  always @(posedge vji_tck) begin
    if (vji_cdr)      tdo_dly <= 1'b0;
    else if (vji_sdr) tdo_dly <= vji_tdi;
  end
  assign vji_tdo = tdo_dly ^ tdo_inv;

  // protocol monitor: strobe one-hotness, change-only-on-tck-fall, per-strobe tck counts
  logic [4:0] strb;
  assign strb = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
  int c_uir = 0, c_cdr = 0, c_sdr = 0, c_udr = 0, c_rti = 0, mon_err = 0;
  logic p_tck = 1'b0, p_tdi = 1'b0;
  logic [4:0] p_strb = '0;
  logic [1:0] p_ir = 2'b00;
  always @(negedge clk) begin
    if (reset_n) begin
      if ($countones(strb) > 1) mon_err++;
      if (vji_tck && strb == 5'b0) mon_err++;
      if (!p_tck && vji_tck) begin
        if (strb != p_strb || vji_tdi != p_tdi || vji_ir_in != p_ir) mon_err++;
        if (vji_uir) c_uir++;
        if (vji_cdr) c_cdr++;
        if (vji_sdr) c_sdr++;
        if (vji_udr) c_udr++;
        if (vji_rti) c_rti++;
      end else if ((strb != p_strb || vji_tdi != p_tdi || vji_ir_in != p_ir) &&
                   !(p_tck && !vji_tck) && !(p_strb == 5'b0 && !vji_tck)) begin
        mon_err++;
      end
    end
    p_tck = vji_tck; p_tdi = vji_tdi; p_strb = strb; p_ir = vji_ir_in;
  end

  int nvec = 0, nerr = 0;
  int b_uir, b_cdr, b_sdr, b_udr, b_rti;
  bit tb_cv = 1'b0;
  logic [1:0] tb_last = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model of the IR cache: UIR is expected unless the cache would hit
  function automatic bit want_uir(input logic [1:0] ir);
    return !(CACHE && tb_cv && ir == tb_last);
  endfunction

  // offers a command at a negedge, keeps cmd_valid high with garbage during the
  // scan (must be ignored), returns clk count from accept cycle to rsp_valid
  task automatic start_scan(input logic [1:0] ir, input logic [DR-1:0] d, output int lat);
    int g;
    g = 0;
    while (!cmd_ready && g < 1000) begin @(negedge clk); g++; end
    b_uir = c_uir; b_cdr = c_cdr; b_sdr = c_sdr; b_udr = c_udr; b_rti = c_rti;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    cmd_ir = ~ir; cmd_data = ~d;
    tb_cv = 1'b1; tb_last = ir;
    lat = 1;
    while (!rsp_valid && lat < 5000) begin @(negedge clk); lat++; end
    cmd_valid = 1'b0;
  endtask

  task automatic check_scan(input string tag, input logic [1:0] ir, input logic [DR-1:0] exp,
                            input bit uir, input int lat);
    chk({tag, "_latency"}, 64'(lat), 64'((DR + (uir ? 4 : 3)) * 2 * TD + 1));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp));
    chk({tag, "_uir_cnt"}, 64'(c_uir - b_uir), 64'(uir ? 1 : 0));
    chk({tag, "_cdr_cnt"}, 64'(c_cdr - b_cdr), 64'd1);
    chk({tag, "_sdr_cnt"}, 64'(c_sdr - b_sdr), 64'(DR));
    chk({tag, "_udr_rti"}, 64'({c_udr - b_udr, c_rti - b_rti}), {32'd1, 32'd1});
    chk({tag, "_ir_in"}, 64'(vji_ir_in), 64'(ir));
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_idle_after"}, 64'({cmd_ready, rsp_valid, vji_tck}), 64'b100);
  endtask

  typedef struct {
    logic [1:0]    ir;
    logic [DR-1:0] data;
    logic          inv;
    logic [DR-1:0] exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int lat;
    bit ok, uir;
    vt[0] = '{2'b01, 38'h2A_5555_AAAA, 1'b0, 38'h14_AAAB_5554};
    vt[1] = '{2'b10, 38'h3F_FFFF_FFFF, 1'b0, 38'h3F_FFFF_FFFE};
    vt[2] = '{2'b10, 38'h00_0000_0000, 1'b1, 38'h3F_FFFF_FFFF};
    vt[3] = '{2'b11, 38'h20_0000_0001, 1'b0, 38'h00_0000_0002};
    vt[4] = '{2'b00, 38'h15_A5A5_0F0F, 1'b1, 38'h14_B4B5_E1E1};

    // reset values, held and then 50 idle clocks after release
    repeat (3) @(negedge clk);
    chk("reset_held", 64'({vji_tck, vji_tdi, vji_ir_in, strb, cmd_ready, rsp_valid}), 64'b0_0_00_00000_1_0);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_outputs", 64'({vji_tck, vji_tdi, vji_ir_in, strb, cmd_ready, rsp_valid}), 64'b0_0_00_00000_1_0);
    chk("idle_rsp_data", 64'(rsp_data), 64'd0);

    // table of scans
    for (int i = 0; i < 5; i++) begin
      tdo_inv = vt[i].inv;
      uir = want_uir(vt[i].ir);
      start_scan(vt[i].ir, vt[i].data, lat);
      check_scan($sformatf("vec%0d", i), vt[i].ir, vt[i].exp, uir, lat);
      finish_rsp($sformatf("vec%0d", i));
    end
    tdo_inv = 1'b0;

    // response back-pressure: everything frozen while rsp_ready stays low
    uir = want_uir(2'b01);
    start_scan(2'b01, vt[0].data, lat);
    check_scan("hold", 2'b01, vt[0].exp, uir, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", i), 64'({rsp_valid, cmd_ready, vji_tck, rsp_data}),
          64'({1'b1, 1'b0, 1'b0, vt[0].exp}));
    end
    finish_rsp("hold");

    // back-to-back with rsp_ready tied high, same IR twice
    rsp_ready = 1'b1;
    uir = want_uir(2'b10);
    start_scan(2'b10, vt[1].data, lat);
    check_scan("b2b_a", 2'b10, vt[1].exp, uir, lat);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_gap_ready", 64'({cmd_ready, rsp_valid}), 64'b10);
    uir = want_uir(2'b10);
    start_scan(2'b10, vt[3].data, lat);
    check_scan("b2b_b", 2'b10, vt[3].exp, uir, lat);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_done", 64'({cmd_ready, rsp_valid}), 64'b10);

    // reset in the middle of SDR, while bit 17 is on the wire
    cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_data = vt[4].data;
    b_sdr = c_sdr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (c_sdr - b_sdr < 18 && lat < 2000) begin @(negedge clk); lat++; end
    chk("rst_reached_bit17", 64'({vji_sdr, 32'(c_sdr - b_sdr)}), 64'({1'b1, 32'd18}));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({vji_tck, vji_tdi, vji_ir_in, strb, cmd_ready, rsp_valid}), 64'b0_0_00_00000_1_0);
    chk("rst_async_rsp_data", 64'(rsp_data), 64'd0);
    tb_cv = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || vji_tck || strb != 5'b0) ok = 1'b0;
    end
    chk("rst_no_response", 64'(ok), 64'd1);

    // next command after the aborted scan completes normally
    uir = want_uir(2'b11);
    start_scan(2'b11, vt[0].data, lat);
    check_scan("post_rst", 2'b11, vt[0].exp, uir, lat);
    finish_rsp("post_rst");

    chk("protocol_monitor_errors", 64'(mon_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
